sub_b: RTL and testbench

SUB_B -- requirements
Module: sub_b

---
 rtl/sub_b.sv | 128 ++++++++++++
 tb/tb_sub_b.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sub_b.sv
// Strobe-qualified serial frame receiver (start bit, LSB-first payload, even parity)
// feeding a small output FIFO with valid/ready handshake and error/overflow pulses.
//
// state | meaning
// IDLE  | waiting for a strobed start bit (1)
// DATA  | collecting DATA_W strobed payload bits, LSB first
// PAR   | waiting for the strobed even-parity bit
module sub_b #(
  parameter int DATA_W = 8,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sub_a__sub_b__s1,
  input  logic              ssub_b__sub_b__s1,
  output logic [DATA_W-1:0] sub_b__top__data,
  output logic              sub_b__top__vld,
  input  logic              top__sub_b__rdy,
  output logic              sub_b__top__perr,
  output logic              sub_b__top__ovf
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int OCC_W = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic stb;
  logic sin;
  logic last_bit;
  logic start_det;
  logic bit_we;
  logic frame_done;
  logic par_ok;
  logic full;
  logic pop;
  logic push;
  logic drop_ovf;
  logic drop_perr;

  assign stb      = ssub_b__sub_b__s1;
  assign sin      = sub_a__sub_b__s1;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stb && sin)      state_nxt = DATA;
      DATA:    if (stb && last_bit) state_nxt = PAR;
      PAR:     if (stb)             state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // A full buffer still accepts a frame when the head is popped in the same cycle.
  always_comb begin
    start_det  = (state == IDLE) && stb && sin;
    bit_we     = (state == DATA) && stb;
    frame_done = (state == PAR) && stb;
    par_ok     = ~(^{shift_r, sin});
    full       = (occ == OCC_W'(FIFO_D));
    pop        = sub_b__top__vld && top__sub_b__rdy;
    push       = frame_done && par_ok && (!full || pop);
    drop_ovf   = frame_done && par_ok && full && !pop;
    drop_perr  = frame_done && !par_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shift_r <= '0;
    end else begin
      if (start_det)   bit_cnt <= '0;
      else if (bit_we) bit_cnt <= bit_cnt + 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
        if (bit_we && (bit_cnt == CNT_W'(i))) shift_r[i] <= sin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      sub_b__top__perr <= 1'b0;
      sub_b__top__ovf  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      sub_b__top__perr <= drop_perr;
      sub_b__top__ovf  <= drop_ovf;
    end
  end

  // Data is forced to zero while empty so reset and idle show a clean bus.
  assign sub_b__top__vld  = (occ != '0);
  assign sub_b__top__data = sub_b__top__vld ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sub_b.sv
// Directed bench for sub_b: frame reception, parity error, overflow, full-with-pop,
// mid-frame reset and strobe gaps, with hand-computed expected values.
module tb_sub_b;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       stb;
  logic [7:0] data;
  logic       vld;
  logic       rdy;
  logic       perr;
  logic       ovf;

  int n_pass;
  int n_total;

  sub_b #(.DATA_W(8), .FIFO_D(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .sub_a__sub_b__s1 (sin),
    .ssub_b__sub_b__s1(stb),
    .sub_b__top__data (data),
    .sub_b__top__vld  (vld),
    .top__sub_b__rdy  (rdy),
    .sub_b__top__perr (perr),
    .sub_b__top__ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_bit(input logic b);
    stb = 1'b1;
    sin = b;
    tick();
    stb = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] d);
    strobe_bit(1'b1);
    for (int i = 0; i < 8; i++) strobe_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_head(d);
    strobe_bit(p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", vld); else n_pass++;
    n_total++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL reset_perr got=%b exp=0", perr); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rdy = 1'b1;
    send_frame(8'hA5, 1'b0);
    n_total++; if (vld !== 1'b1) $display("FAIL basic_vld got=%b exp=1", vld); else n_pass++;
    n_total++; if (data !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", data); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL basic_perr got=%b exp=0", perr); else n_pass++;
    tick();
    n_total++; if (vld !== 1'b0) $display("FAIL basic_popped got=%b exp=0", vld); else n_pass++;
    rdy = 1'b0;
  endtask

  task automatic test_perr();
    send_frame(8'h01, 1'b0);
    n_total++; if (perr !== 1'b1) $display("FAIL perr_pulse got=%b exp=1", perr); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL perr_ovf got=%b exp=0", ovf); else n_pass++;
    n_total++; if (vld !== 1'b0) $display("FAIL perr_vld got=%b exp=0", vld); else n_pass++;
    tick();
    n_total++; if (perr !== 1'b0) $display("FAIL perr_width got=%b exp=0", perr); else n_pass++;
    n_total++; if (vld !== 1'b0) $display("FAIL perr_vld_after got=%b exp=0", vld); else n_pass++;
  endtask

  task automatic test_overflow();
    rdy = 1'b0;
    send_frame(8'h11, 1'b0);
    n_total++; if (data !== 8'h11) $display("FAIL ovf_first got=%h exp=11", data); else n_pass++;
    send_frame(8'h22, 1'b0);
    n_total++; if (data !== 8'h11) $display("FAIL ovf_stable got=%h exp=11", data); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_early got=%b exp=0", ovf); else n_pass++;
    send_frame(8'h33, 1'b0);
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", ovf); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL ovf_perr got=%b exp=0", perr); else n_pass++;
    tick();
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_width got=%b exp=0", ovf); else n_pass++;
    rdy = 1'b1;
    n_total++; if (data !== 8'h11) $display("FAIL ovf_read0 got=%h exp=11", data); else n_pass++;
    tick();
    n_total++; if (data !== 8'h22 || vld !== 1'b1) $display("FAIL ovf_read1 got=%h/%b exp=22/1", data, vld); else n_pass++;
    tick();
    n_total++; if (vld !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", vld); else n_pass++;
    rdy = 1'b0;
  endtask

  task automatic test_full_pop();
    rdy = 1'b0;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_head(8'h33);
    n_total++; if (data !== 8'h11) $display("FAIL fpop_head got=%h exp=11", data); else n_pass++;
    rdy = 1'b1;
    strobe_bit(1'b0);
    n_total++; if (ovf !== 1'b0) $display("FAIL fpop_ovf got=%b exp=0", ovf); else n_pass++;
    n_total++; if (data !== 8'h22 || vld !== 1'b1) $display("FAIL fpop_d1 got=%h/%b exp=22/1", data, vld); else n_pass++;
    tick();
    n_total++; if (data !== 8'h33 || vld !== 1'b1) $display("FAIL fpop_d2 got=%h/%b exp=33/1", data, vld); else n_pass++;
    tick();
    n_total++; if (vld !== 1'b0) $display("FAIL fpop_empty got=%b exp=0", vld); else n_pass++;
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    strobe_bit(1'b1);
    for (int i = 0; i < 4; i++) strobe_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h5A, 1'b0);
    n_total++; if (data !== 8'h5A || vld !== 1'b1) $display("FAIL rmid_data got=%h/%b exp=5a/1", data, vld); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL rmid_perr got=%b exp=0", perr); else n_pass++;
    rdy = 1'b1;
    tick();
    n_total++; if (vld !== 1'b0) $display("FAIL rmid_single got=%b exp=0", vld); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL rmid_perr2 got=%b exp=0", perr); else n_pass++;
    rdy = 1'b0;
  endtask

  task automatic test_gaps();
    logic [9:0] bits;
    bits = {1'b0, 8'hC3, 1'b1};
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) strobe_bit(1'b0);
    n_total++; if (vld !== 1'b0) $display("FAIL gaps_idle0 got=%b exp=0", vld); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) begin
        repeat ($urandom_range(0, 3)) begin
          sin = 1'($urandom);
          tick();
        end
      end
      strobe_bit(bits[i]);
    end
    n_total++; if (data !== 8'hC3 || vld !== 1'b1) $display("FAIL gaps_data got=%h/%b exp=c3/1", data, vld); else n_pass++;
    n_total++; if (perr !== 1'b0) $display("FAIL gaps_perr got=%b exp=0", perr); else n_pass++;
    rdy = 1'b1;
    tick();
    n_total++; if (vld !== 1'b0) $display("FAIL gaps_pop got=%b exp=0", vld); else n_pass++;
    rdy = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    stb = 1'b0;
    sin = 1'b0;
    rdy = 1'b0;
    test_reset();
    test_basic();
    test_perr();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_gaps();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
